// File: rtl/kmap_pkg.sv
// Shared types and constants for the K-map truth-table capture block.
package kmap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int VEC_W     = 4;
    localparam int N_VECTORS = 16;
    // Dwell counter sized for the 255-cycle maximum dwell.
    localparam int DWELL_W   = 8;

endpackage

// File: rtl/kmap_vector_seq.sv
// Vector index and dwell counter for the sweep; flags the sample cycle and the last vector.
// Latency: vec_idx resets to 0 on the load edge and steps once per DWELL_CYCLES while running.
module kmap_vector_seq
    import kmap_pkg::*;
#(
    parameter int DWELL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic             halt,
    output logic [VEC_W-1:0] vec_idx,
    output logic             sample_strobe,
    output logic             last_vector
);

    logic [DWELL_W-1:0] dwell;

    assign sample_strobe = run && (dwell == DWELL_W'(DWELL_CYCLES - 1));
    assign last_vector   = (vec_idx == VEC_W'(N_VECTORS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_idx <= '0;
            dwell   <= '0;
        end else if (load) begin
            vec_idx <= '0;
            dwell   <= '0;
        end else if (sample_strobe) begin
            dwell <= '0;
            // Freeze on the final vector or an aborting sample so vec_out keeps showing it.
            if (!last_vector && !halt) begin
                vec_idx <= vec_idx + 1'b1;
            end
        end else if (run) begin
            dwell <= dwell + 1'b1;
        end
    end

endmodule

// File: rtl/kmap_truth_table_capture.sv
// Sweeps all 16 {a,b,c,d} vectors into a K-map block, captures its output and checks it against a masked expectation.
// Optional early abort on first mismatch via KMAP_EARLY_ABORT_EN (adds fail_index).
module kmap_truth_table_capture
    import kmap_pkg::*;
#(
    parameter int DWELL_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N_VECTORS-1:0] expected,
    input  logic [N_VECTORS-1:0] dont_care_mask,
    output logic [VEC_W-1:0]     vec_out,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic [N_VECTORS-1:0] truth_table,
    output logic [N_VECTORS-1:0] mismatch_mask,
    output logic                 pass
`ifdef KMAP_EARLY_ABORT_EN
    ,
    output logic [VEC_W-1:0]     fail_index
`endif
);

    state_t               state;
    logic [N_VECTORS-1:0] exp_q;
    logic [N_VECTORS-1:0] dc_q;
    logic [VEC_W-1:0]     vec_idx;
    logic                 sample_strobe;
    logic                 last_vector;
    logic                 load;
    logic                 run;
    logic                 halt;
    logic [N_VECTORS-1:0] diff;

    assign load = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign run  = (state == ST_APPLY);
    assign diff = (truth_table ^ exp_q) & ~dc_q;

`ifdef KMAP_EARLY_ABORT_EN
    assign halt = sample_strobe && !dc_q[vec_idx] && (dut_out != exp_q[vec_idx]);
`else
    assign halt = 1'b0;
`endif

    kmap_vector_seq #(
        .DWELL_CYCLES (DWELL_CYCLES)
    ) u_seq (
        .clk           (clk),
        .rst           (rst),
        .load          (load),
        .run           (run),
        .halt          (halt),
        .vec_idx       (vec_idx),
        .sample_strobe (sample_strobe),
        .last_vector   (last_vector)
    );

    // vec_idx is itself a register, so the vector drive stays registered.
    assign vec_out = vec_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            exp_q         <= '0;
            dc_q          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            truth_table   <= '0;
            mismatch_mask <= '0;
            pass          <= 1'b0;
`ifdef KMAP_EARLY_ABORT_EN
            fail_index    <= '0;
`endif
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        exp_q         <= expected;
                        dc_q          <= dont_care_mask;
                        truth_table   <= '0;
                        mismatch_mask <= '0;
                        pass          <= 1'b0;
                        done          <= 1'b0;
                        busy          <= 1'b1;
`ifdef KMAP_EARLY_ABORT_EN
                        fail_index    <= '0;
`endif
                        state         <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    if (sample_strobe) begin
                        truth_table[vec_idx] <= dut_out;
                        if (last_vector || halt) begin
                            state <= ST_CHECK;
                        end
`ifdef KMAP_EARLY_ABORT_EN
                        if (halt) begin
                            fail_index <= vec_idx;
                        end
`endif
                    end
                end
                ST_CHECK: begin
                    mismatch_mask <= diff;
                    pass          <= (diff == '0);
                    done          <= 1'b1;
                    busy          <= 1'b0;
                    state         <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
